ss_skid_slice_n: RTL and testbench
==================================

SS_SKID_SLICE_N -- requirements
Module: ss_skid_slice_n

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 2: number of cascaded skid stages; legal range 0..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-003 SHALL have clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have in_valid, input, 1 bit: upstream beat present.
REQ-006 SHALL have in_ready, output, 1 bit: this block accepts a beat; a transfer occurs when in_valid && in_ready at a clock edge.
REQ-007 SHALL have in_data, input, DATA_WIDTH bits: upstream payload.
REQ-008 SHALL have out_valid, output, 1 bit: downstream beat present.
REQ-009 SHALL have out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid && out_ready at a clock edge.
REQ-010 SHALL have out_data, output, DATA_WIDTH bits: downstream payload.

Function
REQ-011 The block SHALL register both the forward path (valid/data) and the backward path (ready); each stage breaks all combinational paths between its two sides.
REQ-012 When NUM_SLICES == 0, the block SHALL be a pure wire: out_valid=in_valid, out_data=in_data, in_ready=out_ready.
REQ-013 When NUM_SLICES > 0, the stages SHALL be cascaded so that stage k output feeds stage k+1 input, with stage 0 on in_* and stage NUM_SLICES-1 on out_*.
REQ-014 Each stage SHALL hold a main register and a skid register, and SHALL run a state machine with states EMPTY (no beats), ONE (main valid), and FULL (main and skid valid).
REQ-015 Stage stage_out_valid SHALL equal (state != EMPTY), and stage_out_data SHALL equal the main register.
REQ-016 Stage stage_in_ready SHALL be a flop, equal to (next_state != FULL), updated every edge; it SHALL NOT depend combinationally on downstream ready.
REQ-017 EMPTY transitions: on accept, load main and go to ONE; otherwise stay in EMPTY.
REQ-018 ONE transitions, covering all four cases:
  - accept with no emit: load skid, go to FULL.
  - accept and emit simultaneously: load main with the new beat, stay in ONE.
  - emit only: go to EMPTY.
  - neither: hold.
REQ-019 FULL transitions: accept is impossible because stage_in_ready is 0. On emit, move skid to main and go to ONE; otherwise hold.
REQ-020 Ordering SHALL be strictly FIFO; no beat may be dropped, duplicated or reordered.
REQ-021 Latency SHALL be exactly NUM_SLICES cycles from input transfer to out_valid, when downstream is always ready.
REQ-022 Sustained throughput SHALL be one beat per cycle with in_valid and out_ready held at 1.
REQ-023 When a stage is in ONE or FULL and its downstream is stalled, out_valid and out_data SHALL remain stable until transferred.
REQ-024 Data registers SHALL load only on accept, to limit toggle power; their reset value is don't-care.
REQ-025 Total storage SHALL be 2*NUM_SLICES beats; with out_ready held at 0, exactly 2*NUM_SLICES beats SHALL be accepted before in_ready falls.

Reset
REQ-026 While rst_n is low, every stage SHALL be forced to EMPTY, out_valid=0, and every stage_in_ready=0, so that in_ready=0.
REQ-027 Reset assertion mid-transfer SHALL immediately discard all held beats, with no partial output.
REQ-028 On the first rising clk edge after rst_n rises, every stage_in_ready SHALL become 1; no transfer is accepted on that edge.

Verification
REQ-029 Pipeline fill (NUM_SLICES=2, DATA_WIDTH=8, out_ready=1): drive beats 0x01..0x08 back-to-back -> out_data shows 0x01..0x08 on consecutive cycles, first beat 2 cycles after its input transfer, no bubbles.
REQ-030 Backpressure capacity (NUM_SLICES=2, out_ready=0): drive in_valid=1 continuously -> exactly 4 beats accepted, then in_ready=0; raise out_ready -> the same 4 beats emerge in order, then streaming resumes at 1 beat per cycle.
REQ-031 Random stress (NUM_SLICES=3): drive random in_valid and out_ready at 50% each over 10,000 cycles -> a scoreboard sees an identical, in-order sequence; out_valid/out_data are stable whenever out_valid && !out_ready.
REQ-032 Pass-through (NUM_SLICES=0): toggle in_valid, out_ready and in_data=0xA5 -> outputs follow in the same cycle with zero latency.
REQ-033 Reset mid-stream (NUM_SLICES=2, stage 0 FULL): assert rst_n=0 asynchronously between edges -> out_valid and in_ready drop to 0 immediately; after release, in_ready=1 one edge later and no stale beat appears.
REQ-034 Single-beat bubble (NUM_SLICES=1): send one beat 0x3C with out_ready=1 -> out_valid is high for exactly 1 cycle, out_data=0x3C, and the stage returns to EMPTY.

Source files
------------

// File: rtl/ss_skid_slice_n.sv
// ss_skid_slice_n: a chain of NUM_SLICES skid-buffer register slices.
// Each slice registers valid, data and ready, so no combinational path
// crosses a slice in either direction. Each slice stores up to two beats:
// a main register that drives the output and a skid register that catches
// the beat accepted in the same cycle the downstream side stalls.
// NUM_SLICES == 0 degenerates to plain wires.
module ss_skid_slice_n #(
  parameter int NUM_SLICES = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  generate
    if (NUM_SLICES == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
    end else begin : g_pipe
      // Element k is the interface between slice k-1 and slice k;
      // element 0 is the block input, element NUM_SLICES the block output.
      logic                  v_chain [NUM_SLICES+1];
      logic                  r_chain [NUM_SLICES+1];
      logic [DATA_WIDTH-1:0] d_chain [NUM_SLICES+1];

      assign v_chain[0]          = in_valid;
      assign d_chain[0]          = in_data;
      assign r_chain[NUM_SLICES] = out_ready;
      assign in_ready            = r_chain[0];
      assign out_valid           = v_chain[NUM_SLICES];
      assign out_data            = d_chain[NUM_SLICES];

      for (genvar k = 0; k < NUM_SLICES; k++) begin : g_stage
        state_t                state_q, state_d;
        logic                  rdy_q, rdy_d;
        logic [DATA_WIDTH-1:0] main_q, main_d;
        logic [DATA_WIDTH-1:0] skid_q, skid_d;
        logic                  main_ld, skid_ld;
        logic                  accept, emit;

        // Next-state, register loads and registered-ready value for this slice.
        always_comb begin
          accept  = v_chain[k] && rdy_q;
          emit    = (state_q != ST_EMPTY) && r_chain[k+1];
          state_d = state_q;
          main_d  = main_q;
          skid_d  = skid_q;
          main_ld = 1'b0;
          skid_ld = 1'b0;
          case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                main_d  = d_chain[k];
                main_ld = 1'b1;
                state_d = ST_ONE;
              end
            end
            ST_ONE: begin
              if (accept && !emit) begin
                skid_d  = d_chain[k];
                skid_ld = 1'b1;
                state_d = ST_FULL;
              end else if (accept && emit) begin
                main_d  = d_chain[k];
                main_ld = 1'b1;
              end else if (emit) begin
                state_d = ST_EMPTY;
              end
            end
            ST_FULL: begin
              // rdy_q is low here, so only the emit case can occur.
              if (emit) begin
                main_d  = skid_q;
                main_ld = 1'b1;
                state_d = ST_ONE;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
          // Ready is registered from the next state, so it never depends
          // combinationally on the downstream ready.
          rdy_d = (state_d != ST_FULL);
        end

        // Control state: reset forces EMPTY with ready low; ready rises on
        // the first edge after reset release.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
          end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
          end
        end

        // Payload registers: no reset, load only when a beat moves in.
        always_ff @(posedge clk) begin
          if (main_ld) main_q <= main_d;
          if (skid_ld) skid_q <= skid_d;
        end

        assign v_chain[k+1] = (state_q != ST_EMPTY);
        assign d_chain[k+1] = main_q;
        assign r_chain[k]   = rdy_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_ss_skid_slice_n.sv
// Bench for ss_skid_slice_n: four instances (0..3 slices, 8-bit data) share
// one stimulus stream; each has its own FIFO reference model.
module tb_ss_skid_slice_n;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       in_ready_w  [4];
  logic       out_valid_w [4];
  logic [7:0] out_data_w  [4];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one FIFO per instance, plus stall-stability tracking.
  logic [7:0] sb_mem  [4][64];
  int         sb_wr   [4];
  int         sb_rd   [4];
  logic       sb_hold [4];
  logic [7:0] sb_held [4];

  ss_skid_slice_n #(.NUM_SLICES(0), .DATA_WIDTH(8)) u_n0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_data(out_data_w[0]));
  ss_skid_slice_n #(.NUM_SLICES(1), .DATA_WIDTH(8)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_data(out_data_w[1]));
  ss_skid_slice_n #(.NUM_SLICES(2), .DATA_WIDTH(8)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_data(in_data), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .out_data(out_data_w[2]));
  ss_skid_slice_n #(.NUM_SLICES(3), .DATA_WIDTH(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .in_data(in_data), .out_valid(out_valid_w[3]), .out_ready(out_ready),
    .out_data(out_data_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; everything is sampled
  // on the falling edge, where it holds the values the next edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sb_wr[i]   = 0;
        sb_rd[i]   = 0;
        sb_hold[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid && in_ready_w[i]) begin
          sb_mem[i][sb_wr[i] % 64] = in_data;
          sb_wr[i]++;
        end
        if (out_valid_w[i] && out_ready) begin
          check("sb_nonempty", 32'(sb_wr[i] != sb_rd[i]), 32'd1);
          if (sb_wr[i] != sb_rd[i]) begin
            check("sb_data", 32'(out_data_w[i]), 32'(sb_mem[i][sb_rd[i] % 64]));
            sb_rd[i]++;
          end
        end
        if (i > 0 && sb_hold[i]) begin
          check("stall_valid", 32'(out_valid_w[i]), 32'd1);
          check("stall_data", 32'(out_data_w[i]), 32'(sb_held[i]));
        end
        sb_hold[i] = out_valid_w[i] && !out_ready;
        sb_held[i] = out_data_w[i];
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset immediately (asynchronously), checks outputs drop, then
  // releases between edges. rel_valid offers a beat across the release edge,
  // which must not be accepted.
  task automatic do_reset(input logic rel_valid);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    #1;
    for (int i = 1; i < 4; i++) begin
      check("rst_in_ready", 32'(in_ready_w[i]), 32'd0);
      check("rst_out_valid", 32'(out_valid_w[i]), 32'd0);
    end
    repeat (2) cyc_start();
    rst_n    = 1'b1;
    in_valid = rel_valid;
    in_data  = 8'hEE;
    @(negedge clk);
    for (int i = 1; i < 4; i++) check("rel_ready_pre", 32'(in_ready_w[i]), 32'd0);
    cyc_start();
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("rel_ready_post", 32'(in_ready_w[i]), 32'd1);
      check("rel_no_accept", 32'(out_valid_w[i]), 32'd0);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) cyc_start();
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("drain_empty", 32'(sb_wr[i] - sb_rd[i]), 32'd0);
  endtask

  initial begin
    int acc [4];
    int emi [4];
    logic exp_v;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    rst_n     = 1'b1;
    #2;
    do_reset(1'b0);

    // Pipeline fill: 8 back-to-back beats, latency equals slice count.
    for (int c = 0; c < 12; c++) begin
      cyc_start();
      in_valid  = (c < 8);
      in_data   = 8'(c + 1);
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        exp_v = (c >= i) && (c < i + 8);
        check("fill_valid", 32'(out_valid_w[i]), 32'(exp_v));
        if (exp_v) check("fill_data", 32'(out_data_w[i]), 32'(c - i + 1));
        check("fill_ready", 32'(in_ready_w[i]), 32'd1);
      end
    end
    drain();

    // Backpressure: capacity is two beats per slice, then full-rate streaming.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin acc[i] = 0; emi[i] = 0; end
    for (int c = 0; c < 12; c++) begin
      cyc_start();
      in_valid  = 1'b1;
      in_data   = 8'(8'h10 + c);
      out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (in_ready_w[i]) acc[i]++;
    end
    for (int i = 0; i < 4; i++) check("bp_accepted", 32'(acc[i]), 32'(2 * i));
    for (int i = 1; i < 4; i++) check("bp_ready_low", 32'(in_ready_w[i]), 32'd0);
    for (int c = 0; c < 20; c++) begin
      cyc_start();
      in_valid  = 1'b1;
      in_data   = 8'(8'h40 + c);
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (out_valid_w[i]) emi[i]++;
    end
    for (int i = 0; i < 4; i++) check("bp_rate", 32'(emi[i]), 32'd20);
    drain();

    // Reset mid-stream with every slice full.
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      cyc_start();
      in_valid  = 1'b1;
      in_data   = 8'(8'h80 + c);
      out_ready = 1'b0;
    end
    @(negedge clk);
    check("mid_full", 32'(in_ready_w[2]), 32'd0);
    check("mid_valid", 32'(out_valid_w[2]), 32'd1);
    #2;
    do_reset(1'b1);
    for (int c = 0; c < 6; c++) begin
      cyc_start();
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 1; i < 4; i++) check("mid_no_stale", 32'(out_valid_w[i]), 32'd0);
    end

    // Single beat through one slice.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc_start();
      in_valid  = (c == 0);
      in_data   = (c == 0) ? 8'h3C : 8'h00;
      out_ready = 1'b1;
      @(negedge clk);
      check("bubble_valid", 32'(out_valid_w[1]), 32'(c == 1));
      if (c == 1) check("bubble_data", 32'(out_data_w[1]), 32'h3C);
    end
    check("bubble_ready", 32'(in_ready_w[1]), 32'd1);
    drain();

    // Pass-through: zero-slice instance follows inputs without a clock.
    for (int c = 0; c < 8; c++) begin
      #3;
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = (c % 2 == 0) ? 8'hA5 : 8'($urandom);
      #1;
      check("wire_valid", 32'(out_valid_w[0]), 32'(in_valid));
      check("wire_ready", 32'(in_ready_w[0]), 32'(out_ready));
      check("wire_data", 32'(out_data_w[0]), 32'(in_data));
    end

    // Random stress at 50% valid / 50% ready.
    do_reset(1'b0);
    for (int c = 0; c < 10000; c++) begin
      cyc_start();
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = 8'($urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
